// File: rtl/wb_arbiter.sv
// wb_arbiter: queues results from three producers and grants up to two per cycle onto the register-file write ports
// Ports: clk/reset (sync, active-high); wb_hold stalls grants.
// Per producer (ex, mem, lu): rd_en/rd_add/rd_data in, rd_ready out.
// Write ports: wrd_en1/2, wrd_add1/2, wrd_data1/2 (registered).
// wb_busy flags any queued result or any live strobe.
module wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_hold,
  input  logic        ex_rd_en,
  input  logic        mem_rd_en,
  input  logic        lu_rd_en,
  input  logic [6:0]  ex_rd_add,
  input  logic [6:0]  mem_rd_add,
  input  logic [6:0]  lu_rd_add,
  input  logic [31:0] ex_rd_data,
  input  logic [31:0] mem_rd_data,
  input  logic [31:0] lu_rd_data,
  output logic        ex_rd_ready,
  output logic        mem_rd_ready,
  output logic        lu_rd_ready,
  output logic        wrd_en1,
  output logic        wrd_en2,
  output logic [6:0]  wrd_add1,
  output logic [6:0]  wrd_add2,
  output logic [31:0] wrd_data1,
  output logic [31:0] wrd_data2,
  output logic        wb_busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic          en [3];
  logic [6:0]    in_add [3];
  logic [31:0]   in_data [3];
  logic [6:0]    add_q [3][DEPTH];
  logic [31:0]   data_q [3][DEPTH];
  logic [AW-1:0] wp_q [3];
  logic [AW-1:0] rp_q [3];
  logic [CW-1:0] cnt_q [3];
  logic [2:0]    rdy, push, pop, ne;
  logic [6:0]    head_add [3];
  logic [31:0]   head_data [3];
  logic [1:0]    rr_q, rr_d, base;
  logic [1:0]    ord [3];
  logic [1:0]    g1, g2;
  logic          g1_v, g2_v, seen2;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return x >= 2'd2 ? 2'd0 : x + 2'd1;
  endfunction

  assign en      = '{ex_rd_en, mem_rd_en, lu_rd_en};
  assign in_add  = '{ex_rd_add, mem_rd_add, lu_rd_add};
  assign in_data = '{ex_rd_data, mem_rd_data, lu_rd_data};
  assign ex_rd_ready  = rdy[0];
  assign mem_rd_ready = rdy[1];
  assign lu_rd_ready  = rdy[2];
  assign wb_busy = |ne || wrd_en1 || wrd_en2;

  // Writes to x0 are acknowledged but never stored.
  always_comb
    for (int i = 0; i < 3; i++) begin
      rdy[i]       = !reset && cnt_q[i] < FULL;
      push[i]      = en[i] && rdy[i] && in_add[i] != 7'h00;
      ne[i]        = cnt_q[i] != '0;
      head_add[i]  = add_q[i][rp_q[i]];
      head_data[i] = data_q[i][rp_q[i]];
    end

  // Only the second head found competes for port 2; if it targets the same
  // register as port 1 it waits, so same-register writes stay in order.
  always_comb begin
    base   = rr_q == 2'd3 ? 2'd0 : rr_q;
    ord[0] = base;
    ord[1] = inc3(base);
    ord[2] = inc3(inc3(base));
    g1_v   = 1'b0;
    g1     = 2'd0;
    g2_v   = 1'b0;
    g2     = 2'd0;
    seen2  = 1'b0;
    for (int k = 0; k < 3; k++)
      if (ne[ord[k]]) begin
        if (!g1_v) begin
          g1_v = 1'b1;
          g1   = ord[k];
        end else if (!seen2) begin
          seen2 = 1'b1;
          g2    = ord[k];
          g2_v  = head_add[ord[k]] != head_add[g1];
        end
      end
    g1_v = g1_v && !wb_hold;
    g2_v = g2_v && !wb_hold;
    for (int i = 0; i < 3; i++)
      pop[i] = (g1_v && g1 == 2'(i)) || (g2_v && g2 == 2'(i));
    rr_d = g1_v ? inc3(g2_v ? g2 : g1) : rr_q;
  end

  always_ff @(posedge clk)
    for (int i = 0; i < 3; i++)
      if (push[i]) begin
        add_q[i][wp_q[i]]  <= in_add[i];
        data_q[i][wp_q[i]] <= in_data[i];
      end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        wp_q[i]  <= '0;
        rp_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
      rr_q      <= 2'd0;
      wrd_en1   <= 1'b0;
      wrd_en2   <= 1'b0;
      wrd_add1  <= '0;
      wrd_add2  <= '0;
      wrd_data1 <= '0;
      wrd_data2 <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (push[i]) wp_q[i] <= wp_q[i] + AW'(1);
        if (pop[i]) rp_q[i] <= rp_q[i] + AW'(1);
        cnt_q[i] <= cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      end
      rr_q    <= rr_d;
      wrd_en1 <= g1_v;
      wrd_en2 <= g2_v;
      if (g1_v) begin
        wrd_add1  <= head_add[g1];
        wrd_data1 <= head_data[g1];
      end
      if (g2_v) begin
        wrd_add2  <= head_add[g2];
        wrd_data2 <= head_data[g2];
      end
    end
  end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter for the core's two register-file write ports. It collects results from three producers (execute, memory read, long-latency unit) into small per-producer FIFOs. Each cycle it grants up to two FIFO heads round-robin onto the registered ports `wrd_en1/add1/data1` and `wrd_en2/add2/data2`. Those ports feed the register file and the operand-forwarding stage.

## Interface
Parameters:
- `DEPTH`, 2: entries per producer FIFO (power of two, ≥2).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `wb_hold`  in  1  register file busy; no grants while high.
- `ex_rd_en`, `mem_rd_en`, `lu_rd_en`  in  1 each  producer result valid.
- `ex_rd_add`, `mem_rd_add`, `lu_rd_add`  in  7 each  tagged destination {tag[1:0], reg[4:0]}.
- `ex_rd_data`, `mem_rd_data`, `lu_rd_data`  in  32 each  result.
- `ex_rd_ready`, `mem_rd_ready`, `lu_rd_ready`  out  1 each  producer may present a result.
- `wrd_en1`, `wrd_en2`  out  1  write-port strobes (registered).
- `wrd_add1`, `wrd_add2`  out  7  write-port addresses (registered).
- `wrd_data1`, `wrd_data2`  out  32  write-port data (registered).
- `wb_busy`  out  1  any FIFO non-empty or any port strobe high.

## Operation
- Requester index order: ex=0, mem=1, lu=2.
- Enqueue:
  - A result enqueues when `*_rd_en & *_rd_ready`.
  - `*_rd_ready = !reset & (count < DEPTH)`, evaluated on the pre-edge count.
  - A full FIFO does not accept a result, even in a cycle where it dequeues (no pass-through).
- x0 drop: an enqueue with `add == 7'h00` is accepted (ready honoured) but not stored.
- Per-FIFO count: 0..DEPTH, with `log2(DEPTH)+1` bits. Read and write pointers wrap modulo DEPTH.
- Grant, evaluated each cycle when `!wb_hold`:
  - Scan non-empty heads starting from `rr_ptr`, in order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
  - First head found → port 1.
  - Next head found → port 2, only if its address differs from the port-1 address. On an address match it is skipped this cycle (preserves write order to the same register).
  - Granted heads dequeue at the edge.
- rr_ptr (2 bits, values 0..2):
  - After a cycle with ≥1 grant, it becomes (last granted index + 1) mod 3.
  - Otherwise it is unchanged.
  - Value 3 is unreachable. If it is reached, it is treated as 0.
- Port registers load at each edge:
  - `wrd_en1` = port-1 grant, `wrd_en2` = port-2 grant.
  - add/data are loaded from the granted head, otherwise held at their previous value.
  - While `wb_hold` is high, both strobes are 0 and the FIFOs retain their contents.
- Enqueue and grant are independent. Enqueue continues during `wb_hold`.

## Timing
- Reset values:
  - All counts/pointers 0; `rr_ptr` = 0.
  - `wrd_en1/2` = 0, `wrd_add1/2` = 0, `wrd_data1/2` = 0.
  - `*_rd_ready` = 0 while reset is high.
  - `wb_busy` = 0.
- Reset asserted mid-operation: all queued results are discarded at that edge, and the strobes drop at that edge.
- Latency: a result presented in cycle N with an empty FIFO and no competition appears on a write port in cycle N+2 (enqueue at edge N, grant/register at edge N+1).
- Throughput:
  - Up to 3 enqueues and 2 writes per cycle.
  - With all three producers enqueuing every cycle, the FIFOs fill, and readiness then throttles producers to a sustained total of 2 per cycle.
- `wb_busy` is combinational from the counts and the strobe registers.
- Same-register ordering is guaranteed only across ports within a cycle. Producers must not issue two in-flight writes to the same address from different FIFOs in conflicting order.

## Test plan
- **Single write.** Reset, then `ex_rd_en=1, ex_rd_add=7'h25, ex_rd_data=32'hDEADBEEF` for one cycle → `wrd_en1=1, wrd_add1=7'h25, wrd_data1=32'hDEADBEEF` exactly 2 cycles later; `wrd_en2=0`; `wb_busy` low afterwards.
- **Round-robin.** ex, mem and lu all enqueue distinct addresses 7'h01/7'h02/7'h03 in the same cycle:
  - First grant cycle: port1=01, port2=02.
  - Next cycle: port1=03.
  - Then `rr_ptr=0`.
- **Address conflict.** ex and mem both enqueue 7'h0A (data 1 and 2) → port1 writes 7'h0A data 1 while port2 stays idle; mem's write to 7'h0A on port 1 follows in the next cycle.
- **Backpressure.** With DEPTH=2 and `wb_hold=1`, ex presents 3 consecutive results → `ex_rd_ready` drops after 2 accepts. After `wb_hold` drops, the two stored results drain in order and ready returns to 1.
- **x0 drop.** ex enqueues `add=7'h00` → ready=1, count stays 0, no strobe, `wb_busy` stays 0.
- **Mid-operation reset.** Fill all FIFOs, then assert reset for one cycle → all strobes 0 and counts 0; no queued data appears after reset releases.
